// File: rtl/amm_arbiter_if.sv
// avalon_mm_if: Avalon-MM command/response bundle.
// master drives commands; slave answers with waitrequest and read data.
interface avalon_mm_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 4
);
    logic                  write;
    logic                  read;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [BURST_W-1:0]    burstcount;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output write, read, address, byteenable, burstcount, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  write, read, address, byteenable, burstcount, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/amm_arbiter.sv
// amm_arbiter: N:1 Avalon-MM arbiter, burst-locked writes, in-order read tag FIFO.
// Define AMM_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module amm_arbiter #(
    parameter int MASTERS_CNT   = 2,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 64,
    parameter int BURST_W       = 4,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    avalon_mm_if.slave  amm_if_m [MASTERS_CNT],
    avalon_mm_if.master amm_if_s
);
    localparam int IDW = (MASTERS_CNT > 1) ? $clog2(MASTERS_CNT) : 1;
    localparam int PW  = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int BEW = DATA_W / 8;
    localparam logic [PW:0]        DEPTH_C = (PW+1)'(RD_FIFO_DEPTH);
    localparam logic [BURST_W-1:0] ONE_C   = BURST_W'(1);

    typedef enum logic {IDLE = 1'b0, WR_BURST = 1'b1} state_t;

    logic [MASTERS_CNT-1:0] m_wr;
    logic [MASTERS_CNT-1:0] m_rd;
    logic [MASTERS_CNT-1:0] req;
    logic [MASTERS_CNT-1:0] m_wait;
    logic [MASTERS_CNT-1:0] m_rdv;
    logic [ADDR_W-1:0]      m_addr [MASTERS_CNT];
    logic [BEW-1:0]         m_be   [MASTERS_CNT];
    logic [BURST_W-1:0]     m_bc   [MASTERS_CNT];
    logic [DATA_W-1:0]      m_wd   [MASTERS_CNT];

    state_t             state_q, state_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]     lock_q, lock_d;
`ifndef AMM_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     rr_q, rr_d;
`endif

    logic               arb_vld;
    logic [IDW-1:0]     arb_id;
    logic               gnt_vld;
    logic [IDW-1:0]     gnt_id;
    logic               g_wr;
    logic               g_rd;
    logic [BURST_W-1:0] g_bc;
    logic [BURST_W-1:0] bc_eff;
    logic               rd_blk;
    logic               s_wr;
    logic               s_rd;
    logic               acc_wr;
    logic               acc_rd;

    logic [IDW-1:0]     tag_id_q [RD_FIFO_DEPTH];
    logic [BURST_W-1:0] tag_bc_q [RD_FIFO_DEPTH];
    logic [PW-1:0]      wptr_q;
    logic [PW-1:0]      rptr_q;
    logic [PW:0]        occ_q;
    logic [BURST_W-1:0] beat_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [IDW-1:0]     head_id;
    logic [BURST_W-1:0] head_bc;
    logic               rsp_vld;
    logic               push;
    logic               pop;

    for (genvar g = 0; g < MASTERS_CNT; g++) begin : g_port
        assign m_wr[g]   = amm_if_m[g].write;
        assign m_rd[g]   = amm_if_m[g].read;
        assign m_addr[g] = amm_if_m[g].address;
        assign m_be[g]   = amm_if_m[g].byteenable;
        assign m_bc[g]   = amm_if_m[g].burstcount;
        assign m_wd[g]   = amm_if_m[g].writedata;
        assign amm_if_m[g].waitrequest   = m_wait[g];
        assign amm_if_m[g].readdatavalid = m_rdv[g];
        assign amm_if_m[g].readdata      = amm_if_s.readdata;
    end

    assign req = m_wr | m_rd;

`ifdef AMM_ARB_FIXED_PRIO_EN
    // Lowest requesting index wins
    always_comb begin
        arb_vld = 1'b0;
        arb_id  = '0;
        for (int k = MASTERS_CNT - 1; k >= 0; k--) begin
            if (req[k]) begin
                arb_vld = 1'b1;
                arb_id  = IDW'(k);
            end
        end
    end
`else
    // First requester at or after rr+1, scanned backwards so the nearest wins
    always_comb begin
        int idx;
        idx     = 0;
        arb_vld = 1'b0;
        arb_id  = '0;
        for (int k = MASTERS_CNT; k >= 1; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= MASTERS_CNT) idx = idx - MASTERS_CNT;
            if (req[idx]) begin
                arb_vld = 1'b1;
                arb_id  = IDW'(idx);
            end
        end
    end
`endif

    assign gnt_vld = (state_q == WR_BURST) | arb_vld;
    assign gnt_id  = (state_q == WR_BURST) ? lock_q : arb_id;

    // Forward the granted command and build per-master handshakes
    always_comb begin
        g_wr   = m_wr[gnt_id];
        g_rd   = m_rd[gnt_id];
        g_bc   = m_bc[gnt_id];
        bc_eff = (g_bc == '0) ? ONE_C : g_bc;
        rd_blk = g_rd & (fifo_full | (state_q == WR_BURST));
        s_wr   = rst_i & gnt_vld & g_wr;
        s_rd   = rst_i & gnt_vld & g_rd & ~rd_blk;
        m_wait = '1;
        if (rst_i && gnt_vld) begin
            m_wait[gnt_id] = amm_if_s.waitrequest | rd_blk;
        end
        m_rdv = '0;
        if (rsp_vld) begin
            m_rdv[head_id] = 1'b1;
        end
    end

    assign amm_if_s.write      = s_wr;
    assign amm_if_s.read       = s_rd;
    assign amm_if_s.address    = m_addr[gnt_id];
    assign amm_if_s.byteenable = m_be[gnt_id];
    assign amm_if_s.burstcount = g_bc;
    assign amm_if_s.writedata  = m_wd[gnt_id];

    assign acc_wr = s_wr & ~amm_if_s.waitrequest;
    assign acc_rd = s_rd & ~amm_if_s.waitrequest;

    // Next state: burst lock on multi-beat writes, pointer moves on acceptance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
`ifndef AMM_ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (acc_wr && bc_eff > ONE_C) begin
                    state_d = WR_BURST;
                    lock_d  = gnt_id;
                    cnt_d   = bc_eff - ONE_C;
                end else if (acc_wr || acc_rd) begin
`ifndef AMM_ARB_FIXED_PRIO_EN
                    rr_d = gnt_id;
`endif
                end
            end
            WR_BURST: begin
                if (acc_wr) begin
                    cnt_d = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_d = IDLE;
`ifndef AMM_ARB_FIXED_PRIO_EN
                        rr_d    = lock_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, burst lock and arbitration pointer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lock_q  <= '0;
`ifndef AMM_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
`ifndef AMM_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign fifo_full  = (occ_q == DEPTH_C);
    assign fifo_empty = (occ_q == '0);
    assign head_id    = tag_id_q[rptr_q];
    assign head_bc    = tag_bc_q[rptr_q];
    assign rsp_vld    = rst_i & amm_if_s.readdatavalid & ~fifo_empty;
    assign push       = acc_rd;
    assign pop        = rsp_vld & (beat_q == head_bc - ONE_C);

    // Tag FIFO pointers, occupancy and head beat counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            beat_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      occ_q <= occ_q + 1'b1;
            else if (pop && !push) occ_q <= occ_q - 1'b1;
            if (pop)          beat_q <= '0;
            else if (rsp_vld) beat_q <= beat_q + ONE_C;
        end
    end

    // Tag storage written on every accepted read
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_id_q[wptr_q] <= gnt_id;
            tag_bc_q[wptr_q] <= bc_eff;
        end
    end
endmodule

// File: tb/tb_amm_arbiter.sv
// tb_amm_arbiter: randomized bench for amm_arbiter with a transaction-level model.
// Build with AMM_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_amm_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 4;
    localparam int DEPTH = 8;

    typedef struct {
        bit            rd;
        logic [BW-1:0] bc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            id;
        bit            rd;
        logic [BW-1:0] bc;
        logic [DW-1:0] data;
        int            cyc;
    } xact_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]  d_wr = '0;
    logic [N-1:0]  d_rd = '0;
    logic [AW-1:0] d_addr [N];
    logic [BW-1:0] d_bc [N];
    logic [DW-1:0] d_wd [N];
    logic [N-1:0]  o_wait;
    logic [N-1:0]  o_rdv;
    logic [DW-1:0] o_rdata [N];
    logic          s_wait = 1'b0;
    logic          s_rdv = 1'b0;
    logic [DW-1:0] s_rdata = '0;

    avalon_mm_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) m_if [N] ();
    avalon_mm_if #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) s_if ();

    for (genvar g = 0; g < N; g++) begin : g_m
        assign m_if[g].write      = d_wr[g];
        assign m_if[g].read       = d_rd[g];
        assign m_if[g].address    = d_addr[g];
        assign m_if[g].byteenable = '1;
        assign m_if[g].burstcount = d_bc[g];
        assign m_if[g].writedata  = d_wd[g];
        assign o_wait[g]  = m_if[g].waitrequest;
        assign o_rdv[g]   = m_if[g].readdatavalid;
        assign o_rdata[g] = m_if[g].readdata;
    end

    assign s_if.waitrequest   = s_wait;
    assign s_if.readdatavalid = s_rdv;
    assign s_if.readdata      = s_rdata;

    amm_arbiter #(
        .MASTERS_CNT(N), .ADDR_W(AW), .DATA_W(DW),
        .BURST_W(BW), .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .amm_if_m(m_if),
        .amm_if_s(s_if)
    );

    int nchk = 0;
    int nfail = 0;

    beat_t         mq [N][$];
    beat_t         mm [N][$];
    xact_t         slog[$];
    xact_t         exp_log[$];
    int            pres[$];
    logic [DW-1:0] rcv [N][$];
    logic [DW-1:0] exp_rd [N][$];
    logic [DW-1:0] rsp_q[$];
    int            acc_cnt [N];
    int            out_beats = 0;
    int            cyc = 0;
    int            wait_pct = 0;
    int            rsp_pct = 0;
    bit            wait_mode = 0;
    bit            alt_q = 1;

    function automatic beat_t mk(int id, bit rd, int bc);
        beat_t b;
        b.rd   = rd;
        b.bc   = BW'(bc);
        b.addr = {4'(id), 28'($urandom)};
        b.data = {$urandom, $urandom};
        return b;
    endfunction

    task automatic add_txn(int id, bit rd, int bc);
        int n;
        n = rd ? 1 : bc;
        for (int j = 0; j < n; j++) mq[id].push_back(mk(id, rd, bc));
    endtask

    function automatic bit pending();
        bit p;
        p = 0;
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) p = 1;
        return p;
    endfunction

    // Transaction-level arbitration: whole bursts, pick by priority rule
    function automatic void model_build(int rr0);
        int last;
        int pick;
        int n;
        int idx;
        xact_t x;
        last = rr0;
        exp_log.delete();
        for (int i = 0; i < N; i++) mm[i] = mq[i];
        while (1) begin
            pick = -1;
`ifdef AMM_ARB_FIXED_PRIO_EN
            for (int k = 0; k < N; k++)
                if (pick < 0 && mm[k].size() > 0) pick = k;
`else
            for (int k = 1; k <= N; k++) begin
                idx = (last + k) % N;
                if (pick < 0 && mm[idx].size() > 0) pick = idx;
            end
`endif
            if (pick < 0) break;
            n = (!mm[pick][0].rd && mm[pick][0].bc > 1) ? int'(mm[pick][0].bc) : 1;
            for (int j = 0; j < n; j++) begin
                x.id = pick; x.rd = mm[pick][0].rd; x.bc = mm[pick][0].bc;
                x.data = mm[pick][0].data; x.cyc = 0;
                exp_log.push_back(x);
                void'(mm[pick].pop_front());
            end
            last = pick;
        end
    endfunction

    task automatic clear_logs();
        slog.delete();
        pres.delete();
        for (int i = 0; i < N; i++) begin
            rcv[i].delete();
            exp_rd[i].delete();
            acc_cnt[i] = 0;
        end
        cyc = 0;
        alt_q = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        for (int i = 0; i < N; i++) mq[i].delete();
        d_wr = '0; d_rd = '0; s_wait = 0; s_rdv = 0;
        wait_mode = 0; wait_pct = 0; rsp_pct = 0;
        rsp_q.delete();
        out_beats = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        clear_logs();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0) begin
                d_wr[i] = !mq[i][0].rd;
                d_rd[i] = mq[i][0].rd;
                d_addr[i] = mq[i][0].addr;
                d_bc[i] = mq[i][0].bc;
                d_wd[i] = mq[i][0].data;
            end else begin
                d_wr[i] = 0;
                d_rd[i] = 0;
            end
        end
        if (wait_mode) begin
            s_wait = alt_q;
            alt_q = !alt_q;
        end else begin
            s_wait = (int'($urandom_range(99)) < wait_pct);
        end
        s_rdv = 0;
        if (out_beats > 0 && rsp_q.size() > 0 &&
            int'($urandom_range(99)) < rsp_pct) begin
            s_rdv = 1;
            s_rdata = rsp_q[0];
        end
    endtask

    task automatic sample();
        xact_t x;
        int pid;
        nchk++;
        if ((o_rdv & ~{N{s_rdv}}) != '0 || $countones(o_rdv) > 1) begin
            nfail++;
            $display("FAIL rdv_route cyc=%0d got=%b s_rdv=%b required=onehot-with-s_rdv",
                     cyc, o_rdv, s_rdv);
        end
        for (int i = 0; i < N; i++) if (o_rdv[i]) rcv[i].push_back(o_rdata[i]);
        if (s_rdv) begin
            void'(rsp_q.pop_front());
            out_beats--;
        end
        pid = (s_if.write || s_if.read) ? int'(s_if.address[AW-1:AW-4]) : -1;
        pres.push_back(pid);
        if ((s_if.write || s_if.read) && !s_wait) begin
            x.id = pid; x.rd = s_if.read; x.bc = s_if.burstcount;
            x.data = s_if.writedata; x.cyc = cyc;
            slog.push_back(x);
            if (s_if.read) out_beats += (x.bc == 0) ? 1 : int'(x.bc);
        end
        for (int i = 0; i < N; i++) begin
            if ((d_wr[i] || d_rd[i]) && !o_wait[i]) begin
                void'(mq[i].pop_front());
                acc_cnt[i]++;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        drive_inputs();
        #1;
        sample();
    endtask

    task automatic run_until_done(input int maxc, input string tag);
        int n;
        n = 0;
        while ((pending() || (rsp_pct > 0 && out_beats > 0)) && n < maxc) begin
            step();
            n++;
        end
        nchk++;
        if (n >= maxc) begin
            nfail++;
            $display("FAIL %s_timeout cycles=%0d required=<%0d", tag, n, maxc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        d_wr = 2'b11; d_rd = '0; s_rdv = 1; s_wait = 0;
        #1;
        nchk++;
        if (s_if.write !== 1'b0 || s_if.read !== 1'b0) begin
            nfail++;
            $display("FAIL reset_cmd got wr=%b rd=%b required=0/0", s_if.write, s_if.read);
        end
        nchk++;
        if (o_wait !== 2'b11 || o_rdv !== 2'b00) begin
            nfail++;
            $display("FAIL reset_wait got wait=%b rdv=%b required=11/00", o_wait, o_rdv);
        end
        do_reset();
        @(negedge clk);
        #1;
        nchk++;
        if (o_wait !== 2'b11 || s_if.write !== 1'b0) begin
            nfail++;
            $display("FAIL idle_wait got wait=%b wr=%b required=11/0", o_wait, s_if.write);
        end
        add_txn(0, 0, 1);
        step();
        nchk++;
        if (acc_cnt[0] !== 1) begin
            nfail++;
            $display("FAIL first_grant got acc=%0d required=1", acc_cnt[0]);
        end
    endtask

    task automatic test_rr_writes();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            add_txn(0, 0, 1);
            add_txn(1, 0, 1);
        end
        model_build(0);
        run_until_done(50, "rr");
        nchk++;
        if (slog.size() != exp_log.size()) begin
            nfail++;
            $display("FAIL rr_len got=%0d required=%0d", slog.size(), exp_log.size());
        end
        for (int k = 0; k < exp_log.size() && k < slog.size(); k++) begin
            nchk++;
            if (slog[k].id != exp_log[k].id || slog[k].data !== exp_log[k].data) begin
                nfail++;
                $display("FAIL rr_order k=%0d got=m%0d/%h required=m%0d/%h", k,
                         slog[k].id, slog[k].data, exp_log[k].id, exp_log[k].data);
            end
        end
        for (int i = 0; i < N; i++) begin
            nchk++;
            if (acc_cnt[i] != 3) begin
                nfail++;
                $display("FAIL rr_count m%0d got=%0d required=3", i, acc_cnt[i]);
            end
        end
    endtask

    task automatic test_burst_lock();
        int last0;
        do_reset();
        add_txn(1, 0, 1);
        run_until_done(10, "burst_pre");
        clear_logs();
        add_txn(0, 0, 4);
        add_txn(1, 0, 1);
        add_txn(1, 0, 1);
        model_build(1);
        wait_mode = 1;
        run_until_done(60, "burst");
        wait_mode = 0;
        nchk++;
        if (slog.size() != exp_log.size()) begin
            nfail++;
            $display("FAIL burst_len got=%0d required=%0d", slog.size(), exp_log.size());
        end
        last0 = -1;
        for (int k = 0; k < exp_log.size() && k < slog.size(); k++) begin
            nchk++;
            if (slog[k].id != exp_log[k].id || slog[k].data !== exp_log[k].data) begin
                nfail++;
                $display("FAIL burst_order k=%0d got=m%0d/%h required=m%0d/%h", k,
                         slog[k].id, slog[k].data, exp_log[k].id, exp_log[k].data);
            end
            if (slog[k].id == 0) last0 = slog[k].cyc;
        end
        nchk++;
        if (last0 < 0 || last0 + 1 >= pres.size() || pres[last0 + 1] != 1) begin
            nfail++;
            $display("FAIL burst_next got=m%0d required=m1 last0=%0d", (last0 >= 0 &&
                     last0 + 1 < pres.size()) ? pres[last0 + 1] : -9, last0);
        end
    endtask

    task automatic test_read_route();
        logic [DW-1:0] rs [3];
        do_reset();
        rs[0] = 64'hA; rs[1] = 64'hB; rs[2] = 64'hC;
        add_txn(0, 1, 2);
        run_until_done(10, "rd_m0");
        add_txn(1, 1, 1);
        run_until_done(10, "rd_m1");
        for (int j = 0; j < 3; j++) rsp_q.push_back(rs[j]);
        rsp_pct = 100;
        run_until_done(20, "rd_rsp");
        nchk++;
        if (rcv[0].size() != 2 || rcv[1].size() != 1) begin
            nfail++;
            $display("FAIL rd_cnt got=%0d/%0d required=2/1", rcv[0].size(), rcv[1].size());
        end else begin
            nchk++;
            if (rcv[0][0] !== rs[0] || rcv[0][1] !== rs[1]) begin
                nfail++;
                $display("FAIL rd_m0 got=%h,%h required=%h,%h",
                         rcv[0][0], rcv[0][1], rs[0], rs[1]);
            end
            nchk++;
            if (rcv[1][0] !== rs[2]) begin
                nfail++;
                $display("FAIL rd_m1 got=%h required=%h", rcv[1][0], rs[2]);
            end
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int j = 0; j < DEPTH + 1; j++) add_txn(0, 1, 1);
        repeat (20) step();
        nchk++;
        if (acc_cnt[0] != DEPTH || o_wait[0] !== 1'b1 || s_if.read !== 1'b0) begin
            nfail++;
            $display("FAIL fifo_full got acc=%0d wait=%b rd=%b required=%0d/1/0",
                     acc_cnt[0], o_wait[0], s_if.read, DEPTH);
        end
        rsp_q.push_back(64'h1234);
        rsp_pct = 100;
        step();
        rsp_pct = 0;
        nchk++;
        if (acc_cnt[0] != DEPTH || rcv[0].size() != 1) begin
            nfail++;
            $display("FAIL fifo_pop_cycle got acc=%0d rcv=%0d required=%0d/1",
                     acc_cnt[0], rcv[0].size(), DEPTH);
        end
        step();
        nchk++;
        if (acc_cnt[0] != DEPTH + 1) begin
            nfail++;
            $display("FAIL fifo_refill got acc=%0d required=%0d", acc_cnt[0], DEPTH + 1);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        add_txn(1, 1, 1);
        run_until_done(10, "mid_rd");
        add_txn(0, 0, 4);
        step();
        step();
        nchk++;
        if (acc_cnt[0] != 2) begin
            nfail++;
            $display("FAIL mid_beats got=%0d required=2", acc_cnt[0]);
        end
        @(negedge clk);
        drive_inputs();
        #1;
        nchk++;
        if (s_if.write !== 1'b1) begin
            nfail++;
            $display("FAIL mid_fwd got=%b required=1", s_if.write);
        end
        rst_n = 0;
        #1;
        nchk++;
        if (s_if.write !== 1'b0 || o_wait !== 2'b11) begin
            nfail++;
            $display("FAIL mid_rst got wr=%b wait=%b required=0/11", s_if.write, o_wait);
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) mq[i].delete();
        d_wr = '0; d_rd = '0;
        rst_n = 1;
        clear_logs();
        out_beats = 0;
        add_txn(1, 0, 1);
        @(negedge clk);
        drive_inputs();
        #1;
        nchk++;
        if (s_if.write !== 1'b1 || s_if.address[AW-1:AW-4] !== 4'd1 || o_wait[1] !== 1'b0) begin
            nfail++;
            $display("FAIL post_rst_grant got wr=%b id=%0d wait=%b required=1/1/0",
                     s_if.write, s_if.address[AW-1:AW-4], o_wait[1]);
        end
        sample();
        @(negedge clk);
        d_wr = '0; d_rd = '0;
        s_rdv = 1;
        s_rdata = 64'hDEAD;
        #1;
        nchk++;
        if (o_rdv !== 2'b00) begin
            nfail++;
            $display("FAIL post_rst_drop got=%b required=00", o_rdv);
        end
        @(negedge clk);
        s_rdv = 0;
    endtask

    task automatic test_random();
        int nt;
        int r;
        int p;
        int beats;
        logic [DW-1:0] rsp_all[$];
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                nt = $urandom_range(6, 2);
                for (int j = 0; j < nt; j++) begin
                    r = $urandom_range(2);
                    if (r == 0) add_txn(i, 0, 1);
                    else if (r == 1) add_txn(i, 0, $urandom_range(4, 2));
                    else add_txn(i, 1, $urandom_range(4, 1));
                end
            end
            model_build(0);
            beats = 0;
            for (int k = 0; k < exp_log.size(); k++)
                if (exp_log[k].rd) beats += int'(exp_log[k].bc);
            rsp_all.delete();
            for (int k = 0; k < beats; k++) rsp_all.push_back({$urandom, $urandom});
            rsp_q = rsp_all;
            p = 0;
            for (int k = 0; k < exp_log.size(); k++)
                if (exp_log[k].rd)
                    for (int b = 0; b < int'(exp_log[k].bc); b++)
                        exp_rd[exp_log[k].id].push_back(rsp_all[p++]);
            wait_pct = $urandom_range(40);
            rsp_pct = $urandom_range(100, 30);
            run_until_done(3000, "rand");
            nchk++;
            if (slog.size() != exp_log.size()) begin
                nfail++;
                $display("FAIL rand_len it=%0d got=%0d required=%0d",
                         it, slog.size(), exp_log.size());
            end
            for (int k = 0; k < exp_log.size() && k < slog.size(); k++) begin
                nchk++;
                if (slog[k].id != exp_log[k].id || slog[k].rd != exp_log[k].rd ||
                    slog[k].bc !== exp_log[k].bc ||
                    (!exp_log[k].rd && slog[k].data !== exp_log[k].data)) begin
                    nfail++;
                    $display("FAIL rand_order it=%0d k=%0d got=m%0d rd=%0d bc=%0d required=m%0d rd=%0d bc=%0d",
                             it, k, slog[k].id, slog[k].rd, slog[k].bc,
                             exp_log[k].id, exp_log[k].rd, exp_log[k].bc);
                end
            end
            for (int i = 0; i < N; i++) begin
                nchk++;
                if (rcv[i] != exp_rd[i]) begin
                    nfail++;
                    $display("FAIL rand_rdata it=%0d m%0d got_beats=%0d required_beats=%0d",
                             it, i, rcv[i].size(), exp_rd[i].size());
                end
            end
        end
    endtask

`ifdef AMM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        for (int j = 0; j < 6; j++) add_txn(0, 0, 1);
        for (int j = 0; j < 3; j++) add_txn(1, 0, 1);
        repeat (6) step();
        nchk++;
        if (acc_cnt[0] != 6 || acc_cnt[1] != 0) begin
            nfail++;
            $display("FAIL fixed_prio got=%0d/%0d required=6/0", acc_cnt[0], acc_cnt[1]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            d_addr[i] = '0; d_bc[i] = '0; d_wd[i] = '0; acc_cnt[i] = 0;
        end
        test_reset();
        test_rr_writes();
        test_burst_lock();
        test_read_route();
        test_fifo_full();
        test_reset_mid_burst();
        test_random();
`ifdef AMM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
